sparse_mask_match_scheduler: RTL
================================

# sparse_mask_match_scheduler

- Sequences the sparse-MAC operand matcher across one full bitmask pair.
- Accepts a weight bitmask and an activation bitmask, forms their mutual mask (A & W), and walks it from LSB to MSB over several output beats.
- Each beat carries up to MAX_NUM_OUTPUT matched positions, plus each position's dense offset in the compressed W and A streams.
- Sits between the bitmask fetch stage and the sparse MAC buffer-update logic, and replaces software-driven startIndex iteration.

## Interface

Parameters:
- BITMASK_LENGTH, 16, bits per bitmask
- INDEX_BITWIDTH, 5, width of positions, offsets and start index; floor(log2(BITMASK_LENGTH))+1
- MAX_NUM_OUTPUT, 2, max matched positions emitted per beat
- COUNT_BITWIDTH, 2, width of beat count; must hold MAX_NUM_OUTPUT

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ivalid  in  1  upstream mask pair valid
- oready  out  1  ready to accept a mask pair
- bitmaskW  in  BITMASK_LENGTH  weight bitmask, little endian
- bitmaskA  in  BITMASK_LENGTH  activation bitmask, little endian
- ovalid  out  1  output beat valid
- iready  in  1  downstream ready for beat
- resultCount  out  COUNT_BITWIDTH  valid slots in this beat (0..MAX_NUM_OUTPUT)
- resultPos  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  slot k = bit position of k-th match in beat
- resultOffsetW  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  slot k = number of W ones strictly below resultPos[k]
- resultOffsetA  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  same for A
- resultLast  out  1  final beat of current mask pair

## Operation

- States: IDLE and RUN.
- **IDLE:**
  - oready=1, ovalid=0.
  - On ivalid, the block latches W, A and mutual=W&A, and clears startIndex, baseW and baseA.
  - It then goes to RUN.
- **RUN:**
  - oready=0, ovalid=1.
  - The beat is computed combinationally from registered state.
  - The first MAX_NUM_OUTPUT set bits of mutual at positions >= startIndex fill slots 0.. in ascending order.
  - resultOffsetW[k] = baseW + popcount(W bits in [startIndex, pos_k)); resultOffsetA likewise.
  - nextStart = position of last emitted bit + 1.
  - resultLast = 1 when mutual has no set bit at positions >= nextStart.
- **Beat transfer** (ovalid && iready):
  - If resultLast, go to IDLE.
  - Otherwise: startIndex <= nextStart; baseW += popcount(W[startIndex..nextStart-1]); baseA likewise.
- Unused slots (index >= resultCount) are driven 0.
- All result outputs are 0 whenever ovalid=0.
- Widths:
  - Offsets never exceed BITMASK_LENGTH-1.
  - Popcounts are summed at INDEX_BITWIDTH with no overflow possible.
  - The startIndex compare is unsigned.
- **Empty mutual mask:** behaviour set by the Configuration section.

## Timing

- **Reset:** state IDLE, so oready=1 and ovalid=0. All result outputs, startIndex, baseW, baseA and latched masks are 0.
- **Reset mid-RUN:** the in-flight transaction is discarded; IDLE is taken on the next edge. No further beat is emitted.
- **Acceptance:** the handshake completes on the edge where ivalid && oready. The first beat is valid on the following cycle, giving 1-cycle latency.
- **Beat count:** ceil(popcount(mutual)/MAX_NUM_OUTPUT) per pair, with no trailing empty beat.
- **Throughput:** one beat per cycle under iready=1. After the last beat the block spends one cycle in IDLE before RUN.
- **Back-pressure:** while ovalid && !iready, all outputs hold stable and state is frozen.
- **Simultaneous events:** ivalid is ignored outside IDLE. Once ovalid is asserted, it is not withdrawn until the transfer completes.

## Configuration

- Macro: SPARSE_MASK_SCHED_SKIP_EMPTY_EN.
- **Not defined:** an all-zero mutual mask produces exactly one beat with resultCount=0 and resultLast=1. This keeps the downstream stage in per-pair lockstep.
- **Defined:**
  - An all-zero mutual mask produces no beat; the block stays in IDLE, so oready=1 on the next cycle.
  - Back-to-back empty pairs are accepted one per cycle.
  - The RUN state is never entered for them.

## Test plan

- **Two full beats:**
  - Stimulus: W=16'hFFFF, A=16'h00F0, iready=1.
  - Beat1: count 2, pos {4,5}, offW {4,5}, offA {0,1}, last 0.
  - Beat2: pos {6,7}, offW {6,7}, offA {2,3}, last 1.
  - oready returns high the cycle after beat2.
- **Partial last beat:**
  - Stimulus: W=16'h00FF, A=16'h0054.
  - Beat1: count 2, pos {2,4}, offW {2,4}, offA {0,1}, last 0.
  - Beat2: count 1, pos {6,0}, offW {6,0}, offA {2,0}, last 1.
- **Boundary bits:**
  - Stimulus: W=A=16'h8001.
  - Single beat: count 2, pos {0,15}, offW {0,1}, offA {0,1}, last 1.
- **Empty mutual mask:**
  - Stimulus: W=16'hFF00, A=16'h00FF.
  - Macro undefined: one beat, count 0, last 1.
  - Macro defined: ovalid stays 0 and oready=1 every cycle.
- **Back-pressure:**
  - Stimulus: the first scenario with iready=0 for 3 cycles after beat1 appears.
  - Beat1 outputs are held bit-identical for those cycles; beat2 follows one cycle after iready rises.
- **Reset mid-run:**
  - Stimulus: assert reset for 1 cycle while beat1 of the first scenario is stalled.
  - Next cycle: ovalid=0, oready=1, outputs 0.
  - A new pair then starts from startIndex 0.

Source files
------------

// File: rtl/sparse_mask_match_scheduler_if.sv
// Handshake/bus bundle for the sparse mask match scheduler.
// Upstream side: ivalid/oready plus the W/A bitmask pair.
// Downstream side: ovalid/iready plus the per-beat result slots.
interface sparse_mask_match_scheduler_if #(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5,
   parameter int MAX_NUM_OUTPUT = 2,
   parameter int COUNT_BITWIDTH = 2
);
   logic                                     ivalid;
   logic                                     oready;
   logic [BITMASK_LENGTH-1:0]                bitmaskW;
   logic [BITMASK_LENGTH-1:0]                bitmaskA;
   logic                                     ovalid;
   logic                                     iready;
   logic [COUNT_BITWIDTH-1:0]                resultCount;
   logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] resultPos;
   logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] resultOffsetW;
   logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] resultOffsetA;
   logic                                     resultLast;

   // The scheduler itself sits on the slave side.
   modport slave (
      input  ivalid, bitmaskW, bitmaskA, iready,
      output oready, ovalid, resultCount, resultPos, resultOffsetW,
             resultOffsetA, resultLast
   );

   // Mask fetch / buffer-update logic (or a bench) drives the master side.
   modport master (
      output ivalid, bitmaskW, bitmaskA, iready,
      input  oready, ovalid, resultCount, resultPos, resultOffsetW,
             resultOffsetA, resultLast
   );
endinterface

// File: rtl/sparse_mask_match_scheduler.sv
// Purpose: walks the mutual mask (W & A) of one bitmask pair LSB->MSB, emitting up to
//          MAX_NUM_OUTPUT matched positions per beat with their dense offsets into the W/A streams.
// Latency: first beat valid the cycle after ivalid&&oready; then one beat per cycle; backpressure:
//          while ovalid&&!iready all outputs and state are frozen; a new pair is taken only in IDLE.
// Ports: clock, reset (sync, active-high), bus (slave modport: ivalid/oready/bitmaskW/bitmaskA in,
//        ovalid/iready/resultCount/resultPos/resultOffsetW/resultOffsetA/resultLast out).
// Optional feature macro: SPARSE_MASK_SCHED_SKIP_EMPTY_EN -- when defined, a pair whose mutual mask is
// all zero is swallowed in IDLE (no beat); when undefined it yields one beat with count 0, last 1.
module sparse_mask_match_scheduler #(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5,
   parameter int MAX_NUM_OUTPUT = 2,
   parameter int COUNT_BITWIDTH = 2
) (
   input logic                          clock,
   input logic                          reset,
   sparse_mask_match_scheduler_if.slave bus
);

   localparam int SLOTW = MAX_NUM_OUTPUT * INDEX_BITWIDTH;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    state;
   logic                      ovalid_q;
   logic                      oready_q;
   logic [BITMASK_LENGTH-1:0] w_q;
   logic [BITMASK_LENGTH-1:0] a_q;
   logic [BITMASK_LENGTH-1:0] mutual_q;
   logic [INDEX_BITWIDTH-1:0] start_q;
   logic [INDEX_BITWIDTH-1:0] basew_q;
   logic [INDEX_BITWIDTH-1:0] basea_q;

   // Beat contents, derived purely from registered state.
   logic [COUNT_BITWIDTH-1:0] cnt_c;
   logic [SLOTW-1:0]          pos_c;
   logic [SLOTW-1:0]          offw_c;
   logic [SLOTW-1:0]          offa_c;
   logic                      more_c;
   logic [INDEX_BITWIDTH-1:0] next_start_c;
   logic [INDEX_BITWIDTH-1:0] pw_c;
   logic [INDEX_BITWIDTH-1:0] pa_c;
   logic [INDEX_BITWIDTH-1:0] advw_c;
   logic [INDEX_BITWIDTH-1:0] adva_c;
   logic                      last_c;

   // Single LSB->MSB scan from startIndex. pw_c/pa_c hold the W/A ones seen in
   // [startIndex, i) so far, which is exactly the offset increment for a match at i.
   // advw_c/adva_c snapshot the running count through the last emitted bit, i.e. the
   // amount the bases move by when this beat transfers.
   always_comb begin
      cnt_c        = '0;
      pos_c        = '0;
      offw_c       = '0;
      offa_c       = '0;
      more_c       = 1'b0;
      next_start_c = '0;
      pw_c         = '0;
      pa_c         = '0;
      advw_c       = '0;
      adva_c       = '0;
      for (int i = 0; i < BITMASK_LENGTH; i++) begin
         if (INDEX_BITWIDTH'(i) >= start_q) begin
            if (mutual_q[i]) begin
               if (int'(cnt_c) < MAX_NUM_OUTPUT) begin
                  for (int k = 0; k < MAX_NUM_OUTPUT; k++) begin
                     if (k == int'(cnt_c)) begin
                        pos_c[k*INDEX_BITWIDTH +: INDEX_BITWIDTH]  = INDEX_BITWIDTH'(i);
                        offw_c[k*INDEX_BITWIDTH +: INDEX_BITWIDTH] = basew_q + pw_c;
                        offa_c[k*INDEX_BITWIDTH +: INDEX_BITWIDTH] = basea_q + pa_c;
                     end
                  end
                  next_start_c = INDEX_BITWIDTH'(i + 1);
                  advw_c       = pw_c + INDEX_BITWIDTH'(w_q[i]);
                  adva_c       = pa_c + INDEX_BITWIDTH'(a_q[i]);
                  cnt_c        = cnt_c + 1'b1;
               end else begin
                  // A match beyond this beat's capacity: another beat follows.
                  more_c = 1'b1;
               end
            end
            pw_c = pw_c + INDEX_BITWIDTH'(w_q[i]);
            pa_c = pa_c + INDEX_BITWIDTH'(a_q[i]);
         end
      end
      last_c = ~more_c;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         ovalid_q <= 1'b0;
         oready_q <= 1'b1;
         w_q      <= '0;
         a_q      <= '0;
         mutual_q <= '0;
         start_q  <= '0;
         basew_q  <= '0;
         basea_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ivalid) begin
                  w_q      <= bus.bitmaskW;
                  a_q      <= bus.bitmaskA;
                  mutual_q <= bus.bitmaskW & bus.bitmaskA;
                  start_q  <= '0;
                  basew_q  <= '0;
                  basea_q  <= '0;
`ifdef SPARSE_MASK_SCHED_SKIP_EMPTY_EN
                  // Empty pairs are consumed here so the next one can be taken next cycle.
                  if ((bus.bitmaskW & bus.bitmaskA) != '0) begin
                     state    <= RUN;
                     ovalid_q <= 1'b1;
                     oready_q <= 1'b0;
                  end
`else
                  state    <= RUN;
                  ovalid_q <= 1'b1;
                  oready_q <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (bus.iready) begin
                  if (last_c) begin
                     state    <= IDLE;
                     ovalid_q <= 1'b0;
                     oready_q <= 1'b1;
                  end else begin
                     start_q <= next_start_c;
                     basew_q <= basew_q + advw_c;
                     basea_q <= basea_q + adva_c;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               ovalid_q <= 1'b0;
               oready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.oready        = oready_q;
   assign bus.ovalid        = ovalid_q;
   assign bus.resultCount   = ovalid_q ? cnt_c  : '0;
   assign bus.resultPos     = ovalid_q ? pos_c  : '0;
   assign bus.resultOffsetW = ovalid_q ? offw_c : '0;
   assign bus.resultOffsetA = ovalid_q ? offa_c : '0;
   assign bus.resultLast    = ovalid_q & last_c;

endmodule
